// File: rtl/vga_palette_out.sv
// Final VGA output stage: a runtime-writable 16-entry palette turns the scaler's colour
// index into RGB, delays sync/active to match, blanks outside the active area and dims odd lines.
module vga_palette_out #(
  parameter int RGB_BITS = 6
) (
  input  logic                    clk_dot4x,
  input  logic                    rst,
  input  logic [3:0]              pixel_color4,
  input  logic                    hs_in,
  input  logic                    vs_in,
  input  logic                    active_in,
  input  logic [9:0]              v_count,
  input  logic                    scanline_en,
  input  logic                    pal_wr_en,
  input  logic [3:0]              pal_wr_addr,
  input  logic [3*RGB_BITS-1:0]   pal_wr_data,
  output logic [RGB_BITS-1:0]     red,
  output logic [RGB_BITS-1:0]     green,
  output logic [RGB_BITS-1:0]     blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de
);

  localparam int PW = 3 * RGB_BITS;
  localparam int UP = (RGB_BITS > 6) ? RGB_BITS - 6 : 0;
  localparam int DN = (RGB_BITS < 6) ? 6 - RGB_BITS : 0;

  // Default table is stored at 6 bits per channel and rescaled to the channel width.
  function automatic logic [RGB_BITS-1:0] scale6(input logic [5:0] v);
    logic [RGB_BITS+5:0] wide;
    wide = {{RGB_BITS{1'b0}}, v};
    return RGB_BITS'((wide << UP) >> DN);
  endfunction

  function automatic logic [PW-1:0] default_entry(input logic [3:0] idx);
    logic [5:0] r, g, b;
    case (idx)
      4'd0:    {r, g, b} = {6'd0,  6'd0,  6'd0};
      4'd1:    {r, g, b} = {6'd63, 6'd63, 6'd63};
      4'd2:    {r, g, b} = {6'd26, 6'd13, 6'd10};
      4'd3:    {r, g, b} = {6'd28, 6'd41, 6'd44};
      4'd4:    {r, g, b} = {6'd27, 6'd15, 6'd33};
      4'd5:    {r, g, b} = {6'd22, 6'd35, 6'd16};
      4'd6:    {r, g, b} = {6'd13, 6'd10, 6'd30};
      4'd7:    {r, g, b} = {6'd46, 6'd49, 6'd27};
      4'd8:    {r, g, b} = {6'd27, 6'd19, 6'd9};
      4'd9:    {r, g, b} = {6'd16, 6'd14, 6'd0};
      4'd10:   {r, g, b} = {6'd38, 6'd25, 6'd22};
      4'd11:   {r, g, b} = {6'd17, 6'd17, 6'd17};
      4'd12:   {r, g, b} = {6'd27, 6'd27, 6'd27};
      4'd13:   {r, g, b} = {6'd38, 6'd52, 6'd33};
      4'd14:   {r, g, b} = {6'd27, 6'd23, 6'd45};
      4'd15:   {r, g, b} = {6'd37, 6'd37, 6'd37};
      default: {r, g, b} = {6'd0,  6'd0,  6'd0};
    endcase
    return {scale6(r), scale6(g), scale6(b)};
  endfunction

  logic            hs_s0, vs_s0, act_s0, odd_s0;
  logic            hs_s1, vs_s1, act_s1, odd_s1;
  logic            hs_s2, vs_s2, act_s2, odd_s2;
  logic [3:0]      idx_s1;
  logic [PW-1:0]   rgb_s2;
  logic [PW-1:0]   palette [16];

  logic [RGB_BITS-1:0] red_next, green_next, blue_next;
  logic                unused_vcount;

  assign unused_vcount = ^v_count[9:1];

  // Palette storage; a write in the same cycle as an S2 read is seen only from the next read.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) palette[i] <= default_entry(4'(i));
    end else if (pal_wr_en) begin
      palette[pal_wr_addr] <= pal_wr_data;
    end
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      {hs_s0, vs_s0, act_s0, odd_s0} <= {1'b1, 1'b1, 1'b0, 1'b0};
      {hs_s1, vs_s1, act_s1, odd_s1} <= {1'b1, 1'b1, 1'b0, 1'b0};
      {hs_s2, vs_s2, act_s2, odd_s2} <= {1'b1, 1'b1, 1'b0, 1'b0};
      idx_s1 <= 4'd0;
      rgb_s2 <= '0;
    end else begin
      {hs_s0, vs_s0, act_s0, odd_s0} <= {hs_in, vs_in, active_in, v_count[0]};
      {hs_s1, vs_s1, act_s1, odd_s1} <= {hs_s0, vs_s0, act_s0, odd_s0};
      {hs_s2, vs_s2, act_s2, odd_s2} <= {hs_s1, vs_s1, act_s1, odd_s1};
      // The index arrives one clock behind its sync, so it joins the pipe at S1.
      idx_s1 <= pixel_color4;
      rgb_s2 <= palette[idx_s1];
    end
  end

  always_comb begin
    red_next   = '0;
    green_next = '0;
    blue_next  = '0;
    if (!act_s2) begin
      red_next   = '0;
      green_next = '0;
      blue_next  = '0;
    end else if (scanline_en && odd_s2) begin
      red_next   = rgb_s2[PW-1 -: RGB_BITS] >> 1;
      green_next = rgb_s2[2*RGB_BITS-1 -: RGB_BITS] >> 1;
      blue_next  = rgb_s2[RGB_BITS-1:0] >> 1;
    end else begin
      red_next   = rgb_s2[PW-1 -: RGB_BITS];
      green_next = rgb_s2[2*RGB_BITS-1 -: RGB_BITS];
      blue_next  = rgb_s2[RGB_BITS-1:0];
    end
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
    end else begin
      red   <= red_next;
      green <= green_next;
      blue  <= blue_next;
      hsync <= hs_s2;
      vsync <= vs_s2;
      de    <= act_s2;
    end
  end

endmodule

// File: tb/tb_vga_palette_out.sv
// Self-checking bench for vga_palette_out: directed sequences, a steady-state vector
// table, and randomized traffic compared every cycle against a cycle-history model.
module tb_vga_palette_out;

  logic        clk_dot4x;
  logic        rst;
  logic [3:0]  pixel_color4;
  logic        hs_in, vs_in, active_in;
  logic [9:0]  v_count;
  logic        scanline_en;
  logic        pal_wr_en;
  logic [3:0]  pal_wr_addr;
  logic [17:0] pal_wr_data;
  logic [5:0]  red, green, blue;
  logic        hsync, vsync, de;

  int n_tests = 0;
  int n_fail  = 0;

  vga_palette_out #(.RGB_BITS(6)) dut (
    .clk_dot4x(clk_dot4x), .rst(rst), .pixel_color4(pixel_color4),
    .hs_in(hs_in), .vs_in(vs_in), .active_in(active_in), .v_count(v_count),
    .scanline_en(scanline_en), .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de)
  );

  initial clk_dot4x = 1'b0;
  always #5 clk_dot4x = ~clk_dot4x;

  int def_r[16] = '{0, 63, 26, 28, 27, 22, 13, 46, 27, 16, 38, 17, 27, 38, 27, 37};
  int def_g[16] = '{0, 63, 13, 41, 15, 35, 10, 49, 19, 14, 25, 17, 27, 52, 23, 37};
  int def_b[16] = '{0, 63, 10, 44, 33, 16, 30, 27,  9,  0, 22, 17, 27, 33, 45, 37};

  // Reference model: output at edge t = inputs sampled at t-3 (sync/active/line parity),
  // colour of the index sampled at t-2 looked up before the writes of edge t-1.
  int   m_r[16], m_g[16], m_b[16];
  logic h_hs[3], h_vs[3], h_act[3], h_odd[3];
  logic [3:0] h_pix;
  int   rd_r, rd_g, rd_b, n_r, n_g, n_b;
  int   e_r, e_g, e_b;
  logic e_hs, e_vs, e_de, dim;

  always begin
    @(posedge clk_dot4x);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_r[i] = def_r[i]; m_g[i] = def_g[i]; m_b[i] = def_b[i];
      end
      for (int i = 0; i < 3; i++) begin
        h_hs[i] = 1'b1; h_vs[i] = 1'b1; h_act[i] = 1'b0; h_odd[i] = 1'b0;
      end
      h_pix = 4'd0; rd_r = 0; rd_g = 0; rd_b = 0;
      e_r = 0; e_g = 0; e_b = 0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
    end else begin
      e_hs = h_hs[2]; e_vs = h_vs[2]; e_de = h_act[2];
      dim  = e_de && scanline_en && h_odd[2];
      e_r  = !e_de ? 0 : (dim ? rd_r / 2 : rd_r);
      e_g  = !e_de ? 0 : (dim ? rd_g / 2 : rd_g);
      e_b  = !e_de ? 0 : (dim ? rd_b / 2 : rd_b);
      n_r = m_r[h_pix]; n_g = m_g[h_pix]; n_b = m_b[h_pix];
      if (pal_wr_en) begin
        m_r[pal_wr_addr] = int'(pal_wr_data[17:12]);
        m_g[pal_wr_addr] = int'(pal_wr_data[11:6]);
        m_b[pal_wr_addr] = int'(pal_wr_data[5:0]);
      end
      rd_r = n_r; rd_g = n_g; rd_b = n_b;
      for (int i = 2; i > 0; i--) begin
        h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1]; h_act[i] = h_act[i-1]; h_odd[i] = h_odd[i-1];
      end
      h_hs[0] = hs_in; h_vs[0] = vs_in; h_act[0] = active_in; h_odd[0] = v_count[0];
      h_pix = pixel_color4;
    end
    #1;
    n_tests++;
    if (int'(red) != e_r || int'(green) != e_g || int'(blue) != e_b ||
        hsync != e_hs || vsync != e_vs || de != e_de) begin
      n_fail++;
      $display("FAIL model @%0t: got rgb=%0d,%0d,%0d hs=%0b vs=%0b de=%0b expected rgb=%0d,%0d,%0d hs=%0b vs=%0b de=%0b",
               $time, red, green, blue, hsync, vsync, de, e_r, e_g, e_b, e_hs, e_vs, e_de);
    end
  end

  task automatic tick();
    @(posedge clk_dot4x);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_px(input string name, input int r, input int g, input int b, input int d);
    chk({name, ".red"}, int'(red), r);
    chk({name, ".green"}, int'(green), g);
    chk({name, ".blue"}, int'(blue), b);
    chk({name, ".de"}, int'(de), d);
  endtask

  typedef struct {
    logic [3:0] pix;
    logic       act;
    logic [9:0] vc;
    logic       scan;
    int         r, g, b;
    int         d;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'd1,  1'b0, 10'd0, 1'b0, 0,  0,  0,  0};
    tbl[1]  = '{4'd1,  1'b1, 10'd4, 1'b1, 63, 63, 63, 1};
    tbl[2]  = '{4'd1,  1'b1, 10'd5, 1'b1, 31, 31, 31, 1};
    tbl[3]  = '{4'd1,  1'b1, 10'd5, 1'b0, 63, 63, 63, 1};
    tbl[4]  = '{4'd2,  1'b1, 10'd7, 1'b1, 13, 6,  5,  1};
    tbl[5]  = '{4'd7,  1'b1, 10'd2, 1'b1, 46, 49, 27, 1};
    tbl[6]  = '{4'd7,  1'b1, 10'd3, 1'b1, 23, 24, 13, 1};
    tbl[7]  = '{4'd15, 1'b1, 10'd0, 1'b0, 37, 37, 37, 1};
    tbl[8]  = '{4'd9,  1'b1, 10'd9, 1'b1, 8,  7,  0,  1};
    tbl[9]  = '{4'd0,  1'b1, 10'd1, 1'b1, 0,  0,  0,  1};
    tbl[10] = '{4'd13, 1'b1, 10'd0, 1'b0, 38, 52, 33, 1};
    tbl[11] = '{4'd14, 1'b0, 10'd1, 1'b1, 0,  0,  0,  0};

    rst = 1'b1; pixel_color4 = 4'd0; hs_in = 1'b1; vs_in = 1'b1; active_in = 1'b0;
    v_count = 10'd0; scanline_en = 1'b0; pal_wr_en = 1'b0; pal_wr_addr = 4'd0;
    pal_wr_data = 18'd0;

    // Reset and first pixel latency.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_px("reset", 0, 0, 0, 0);
    chk("reset.hsync", int'(hsync), 1);
    chk("reset.vsync", int'(vsync), 1);
    active_in = 1'b1;
    tick();
    pixel_color4 = 4'd2;
    tick();
    tick();
    tick();
    chk_px("first_pixel", 26, 13, 10, 1);

    // Sync and data-enable alignment.
    for (int i = 0; i < 64; i++) begin
      hs_in        = !(i >= 10 && i <= 57);
      active_in    = (i >= 20);
      pixel_color4 = (i >= 21) ? 4'd1 : 4'd0;
      tick();
      if (i >= 3) begin
        chk("align.hsync", int'(hsync), ((i - 3) >= 10 && (i - 3) <= 57) ? 0 : 1);
        chk("align.de", int'(de), (i >= 23) ? 1 : 0);
        chk("align.red", int'(red), (i >= 23) ? 63 : 0);
      end
    end

    // Blanking with active toggling every cycle.
    hs_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      active_in    = i[0];
      pixel_color4 = 4'd1;
      tick();
      if (i >= 3) begin
        chk("blank.de", int'(de), (i - 3) % 2);
        chk("blank.green", int'(green), ((i - 3) % 2 == 1) ? 63 : 0);
      end
    end

    // Steady-state vector table.
    for (int k = 0; k < 12; k++) begin
      pixel_color4 = tbl[k].pix; active_in = tbl[k].act;
      v_count = tbl[k].vc; scanline_en = tbl[k].scan;
      repeat (4) tick();
      chk_px($sformatf("vec%0d", k), tbl[k].r, tbl[k].g, tbl[k].b, tbl[k].d);
    end

    // Write colliding with an S2 read of the same entry.
    scanline_en = 1'b0; v_count = 10'd0; active_in = 1'b1; pixel_color4 = 4'd0;
    repeat (4) tick();
    pixel_color4 = 4'd6;
    tick();
    pixel_color4 = 4'd0; pal_wr_en = 1'b1; pal_wr_addr = 4'd6; pal_wr_data = {6'd10, 6'd20, 6'd30};
    tick();
    pal_wr_en = 1'b0; pixel_color4 = 4'd6;
    tick();
    chk_px("collide.old", 13, 10, 30, 1);
    pixel_color4 = 4'd0;
    tick();
    chk_px("collide.gap", 0, 0, 0, 1);
    tick();
    chk_px("collide.new", 10, 20, 30, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; pixel_color4 = 4'd6;
    repeat (4) tick();
    chk_px("collide.reset", 13, 10, 30, 1);

    // Back-to-back writes, then a write ignored during reset.
    pal_wr_en = 1'b1; pal_wr_addr = 4'd3; pal_wr_data = {6'd1, 6'd2, 6'd3};
    tick();
    pal_wr_data = {6'd4, 6'd5, 6'd6};
    tick();
    pal_wr_en = 1'b0; pixel_color4 = 4'd3;
    repeat (4) tick();
    chk_px("b2b", 4, 5, 6, 1);
    rst = 1'b1; pal_wr_en = 1'b1; pal_wr_data = {6'd7, 6'd7, 6'd7};
    tick();
    rst = 1'b0; pal_wr_en = 1'b0;
    repeat (4) tick();
    chk_px("wr_in_reset", 28, 41, 44, 1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 399) == 0);
      pixel_color4 = 4'($urandom);
      hs_in        = ($urandom_range(0, 7) != 0);
      vs_in        = ($urandom_range(0, 15) != 0);
      active_in    = ($urandom_range(0, 3) != 0);
      v_count      = 10'($urandom);
      scanline_en  = 1'($urandom);
      pal_wr_en    = ($urandom_range(0, 5) == 0);
      pal_wr_addr  = 4'($urandom);
      pal_wr_data  = 18'($urandom);
      tick();
    end
    rst = 1'b0; pal_wr_en = 1'b0;
    repeat (4) tick();
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_palette_out.md
Name: vga_palette_out

Overview:
- Final VGA output stage, directly downstream of the line-doubling scaler and the VGA sync generator.
- Converts the scaler's 4-bit C64 colour index into RGB through a 16-entry palette that can be rewritten at runtime.
- Delays hsync, vsync and active so they line up with the colour data.
- Blanks the RGB outputs outside the active region and can optionally dim odd VGA lines to give a scanline effect.

Parameters:
RGB_BITS, 6, bits per colour channel; palette entry width is 3*RGB_BITS.

Ports:
clk_dot4x  in  1  4x dot clock; all logic on its rising edge
rst  in  1  reset; synchronous, active-high
pixel_color4  in  4  colour index from the scaler; registered one clock after the matching sync inputs
hs_in  in  1  horizontal sync from the sync generator, active low
vs_in  in  1  vertical sync from the sync generator, active low
active_in  in  1  active-region flag from the sync generator
v_count  in  10  VGA line counter, same timing as hs_in
scanline_en  in  1  enables odd-line dimming
pal_wr_en  in  1  palette write strobe, one-cycle pulse
pal_wr_addr  in  4  palette entry to write
pal_wr_data  in  3*RGB_BITS  {R,G,B}, R in the MSBs
red  out  RGB_BITS  red channel
green  out  RGB_BITS  green channel
blue  out  RGB_BITS  blue channel
hsync  out  1  aligned horizontal sync, active low
vsync  out  1  aligned vertical sync, active low
de  out  1  aligned data enable

Behaviour:
- Reset (rst=1 at a clock edge):
  - red, green and blue go to 0; hsync=1, vsync=1, de=0.
  - All pipeline registers clear to the idle values (sync 1, active 0, index 0).
  - The palette reloads its default table.
  - A write presented during reset is ignored.
  - Reset asserted mid-frame takes effect on the next edge; there is no partial-line recovery.
- Default palette (6-bit R,G,B, entries 0..15):
  0,0,0 / 63,63,63 / 26,13,10 / 28,41,44 / 27,15,33 / 22,35,16 / 13,10,30 / 46,49,27 / 27,19,9 / 16,14,0 / 38,25,22 / 17,17,17 / 27,27,27 / 38,52,33 / 27,23,45 / 37,37,37.
  - If RGB_BITS>6, each default value is left-shifted by RGB_BITS-6.
  - If RGB_BITS<6, each default value is right-shifted by 6-RGB_BITS.
- Pipeline, with cycle n being the edge on which hs_in, vs_in, active_in and v_count are sampled:
  - S0 (edge n): hs, vs, active and v_count[0] are registered.
  - S1 (edge n+1): pixel_color4 is registered (this is the index matching cycle n); the sync signals are delayed by one more stage.
  - S2 (edge n+2): palette read with the registered index; sync signals delayed again.
  - S3 (edge n+3): blanking and dimming are applied, and red, green, blue, hsync, vsync and de are updated together.
  - Total latency: 3 clocks from the sync inputs, 2 clocks from pixel_color4. Every output changes on the same edge.
- Output rules at S3:
  - de = delayed active. If de=0, red, green and blue are 0.
  - If de=1, scanline_en=1 (sampled at S3) and the delayed v_count[0]=1, each channel is the palette value shifted right by 1 (floor).
  - Otherwise the channels carry the palette value unchanged.
- Palette write:
  - When pal_wr_en=1 at edge k, entry pal_wr_addr takes pal_wr_data at edge k.
  - An S2 read of the same entry at edge k returns the old value. Reads from edge k+1 onward return the new value.
  - Back-to-back writes on consecutive cycles are all accepted; the last write to an entry wins.
  - No handshake and no back-pressure.
- Free-running: there is no clock enable. The 2x pixel repeat produced by the sync generator passes through unchanged.
- The palette is 16 x 3*RGB_BITS distributed registers. Asynchronous read of the array feeding the S2 register is permitted.

Test Plan:
- Reset: hold rst 3 cycles, then release with active_in=0, hs_in=1, vs_in=1 -> red/green/blue=0, hsync=1, vsync=1, de=0; with active_in=1 and pixel_color4=2 at the next cycle, outputs read 26,13,10 exactly 3/2 clocks later.
- Alignment: hs_in low at cycles 10..57 -> hsync low at cycles 13..60; active_in rising at cycle 20 with pixel_color4=1 from cycle 21 -> de=1 and rgb=63,63,63 both first at cycle 23.
- Blanking: active_in=0, pixel_color4=1 -> rgb=0 throughout; toggle active_in per cycle -> rgb alternates 63,63,63 and 0,0,0, lagging 3 cycles.
- Scanline: scanline_en=1, index 1; v_count=4 -> 63,63,63; v_count=5 -> 31,31,31; scanline_en=0 with v_count=5 -> 63,63,63.
- Palette write collision: pal_wr_en with addr 6, data {10,20,30} on the same edge that S2 reads index 6 -> old value 13,10,30 appears; the next pixel with index 6 -> 10,20,30; a following reset restores 13,10,30.
- Back-to-back writes: writes to addr 3 then immediately addr 3 again ({1,2,3} then {4,5,6}) -> index 3 reads 4,5,6; a write asserted while rst=1 -> no change to the default table.
